// File: rtl/pipe_pkg.sv
// Shared pipeline-register constants and per-stage payload layouts.
// Stages size pipe_stage_reg with WIDTH = $bits(<payload>).
package pipe_pkg;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [4:0]  rd;
        logic        rd_we;
        logic [5:0]  alu_op;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        rd_we;
        logic [1:0]  mem_op;
    } ex_mem_t;

    localparam int IF_ID_W  = $bits(if_id_t);
    localparam int ID_EX_W  = $bits(id_ex_t);
    localparam int EX_MEM_W = $bits(ex_mem_t);

endpackage

// File: rtl/pipe_slot.sv
// One valid+data entry of a pipeline stage register.
// Clear wins over load; load wins over drop.
module pipe_slot #(
    parameter int WIDTH          = 32,
    parameter bit CLEAR_ON_FLUSH = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic             drop,
    input  logic [WIDTH-1:0] load_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            if (CLEAR_ON_FLUSH)
                data <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (drop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: valid/ready handshake, optional skid
// entry, deferred flush across stalls and saturating backpressure counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter bit SKID           = 1'b1,
    parameter bit CLEAR_ON_FLUSH = 1'b1,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic             flush_pend,
    output logic [CNT_W-1:0] bp_cnt
);

    logic             f;
    logic             p;
    logic             run;
    logic             m_v;
    logic             s_v;
    logic [WIDTH-1:0] m_d;
    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] m_src;
    logic             in_xfer;
    logic             out_xfer;
    logic             m_take;
    logic             m_load;
    logic             m_drop;

    assign f        = (flush | p) & ~stall;
    assign run      = rst & ~stall & ~f;
    assign out_valid = m_v & run;
    assign out_data = m_d;
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // S is always older than a new input, so it refills M first.
    assign m_take = run & (~m_v | out_xfer);
    assign m_load = m_take & (s_v | in_xfer);
    assign m_drop = m_take & ~m_load;
    assign m_src  = s_v ? s_d : in_data;

    pipe_slot #(
        .WIDTH          (WIDTH),
        .CLEAR_ON_FLUSH (CLEAR_ON_FLUSH)
    ) u_main (
        .clk       (clk),
        .rst       (rst),
        .clear     (f),
        .load      (m_load),
        .drop      (m_drop),
        .load_data (m_src),
        .valid     (m_v),
        .data      (m_d)
    );

    generate
        if (SKID) begin : g_skid
            logic s_load;
            logic s_drop;

            // in_ready needs S empty, so S never loads and drains at once.
            assign in_ready = ~s_v & run;
            assign s_load   = in_xfer & ~m_take;
            assign s_drop   = m_take & s_v;

            pipe_slot #(
                .WIDTH          (WIDTH),
                .CLEAR_ON_FLUSH (CLEAR_ON_FLUSH)
            ) u_skid (
                .clk       (clk),
                .rst       (rst),
                .clear     (f),
                .load      (s_load),
                .drop      (s_drop),
                .load_data (in_data),
                .valid     (s_v),
                .data      (s_d)
            );
        end else begin : g_noskid
            assign in_ready = run & (~m_v | out_ready);
            assign s_v      = 1'b0;
            assign s_d      = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            p <= 1'b0;
        else if (f)
            p <= 1'b0;
        else if (flush & stall)
            p <= 1'b1;
    end

    assign flush_pend = p;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            bp_cnt <= '0;
        else if (m_v & run & ~out_ready & (bp_cnt != {CNT_W{1'b1}}))
            bp_cnt <= bp_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_comb begin
        occupancy = OCC_EMPTY;
        if (m_v & s_v)
            occupancy = OCC_FULL;
        else if (m_v | s_v)
            occupancy = OCC_ONE;
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: skid, flush/clear and
// small-counter variants driven from shared stimulus.
module tb_pipe_stage_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic       a_in_ready, a_out_valid, a_flush_pend;
    logic [7:0] a_out_data;
    logic [1:0] a_occ;
    logic [3:0] a_bp;

    logic        b_in_ready, b_out_valid, b_flush_pend;
    logic [7:0]  b_out_data;
    logic [1:0]  b_occ;
    logic [15:0] b_bp;

    logic        c_in_ready, c_out_valid, c_flush_pend;
    logic [7:0]  c_out_data;
    logic [1:0]  c_occ;
    logic [15:0] c_bp;

    int checks   = 0;
    int failures = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(8), .SKID(1'b1), .CLEAR_ON_FLUSH(1'b1), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .occupancy(a_occ), .flush_pend(a_flush_pend), .bp_cnt(a_bp)
    );

    pipe_stage_reg #(.WIDTH(8), .SKID(1'b1), .CLEAR_ON_FLUSH(1'b0), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .occupancy(b_occ), .flush_pend(b_flush_pend), .bp_cnt(b_bp)
    );

    pipe_stage_reg #(.WIDTH(8), .SKID(1'b0), .CLEAR_ON_FLUSH(1'b1), .CNT_W(16)) dut_c (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data),
        .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
        .occupancy(c_occ), .flush_pend(c_flush_pend), .bp_cnt(c_bp)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a negedge with inputs set; handshakes are
    // sampled mid low phase, then we move on to the next negedge.
    task automatic tick(input bit check_c);
        logic [7:0] exp;
        #3;
        if (a_out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(a_out_data), 32'hffff_ffff);
            end else begin
                exp = sb.pop_front();
                chk("out_data", 32'(a_out_data), 32'(exp));
                if (check_c)
                    chk("c_out_data", 32'(c_out_data), 32'(exp));
            end
        end
        if (in_valid && a_in_ready)
            sb.push_back(in_data);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst       = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 32'(a_out_valid), 0);
        chk("rst_occ", 32'(a_occ), 0);
        chk("rst_flush_pend", 32'(a_flush_pend), 0);
        chk("rst_bp", 32'(a_bp), 0);
        chk("rst_in_ready", 32'(a_in_ready), 0);
        rst = 1'b1;
        #1;
        chk("rel_in_ready", 32'(a_in_ready), 1);
        @(negedge clk);

        // Stream 1..8 with out_ready held
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick(1'b1);
            chk("strm_occ", 32'(a_occ), 1);
            chk("strm_lat", 32'(a_out_valid), 1);
            chk("strm_bp", 32'(a_bp), 0);
        end
        in_valid = 1'b0;
        tick(1'b1);
        chk("strm_drain_occ", 32'(a_occ), 0);
        chk("strm_sb_empty", 32'(sb.size()), 0);

        // Skid absorbs one entry under backpressure
        do_reset();
        in_valid = 1'b1; in_data = 8'h0A; out_ready = 1'b0;
        tick(1'b0);
        in_data = 8'h0B;
        #1;
        chk("skid_a_rdy", 32'(a_in_ready), 1);
        chk("noskid_c_rdy", 32'(c_in_ready), 0);
        tick(1'b0);
        chk("skid_full_rdy", 32'(a_in_ready), 0);
        chk("skid_occ2", 32'(a_occ), 2);
        chk("skid_head", 32'(a_out_data), 32'h0A);
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("skid_no_comb_rdy", 32'(a_in_ready), 0);
        chk("noskid_comb_rdy", 32'(c_in_ready), 1);
        tick(1'b0);
        chk("skid_occ1", 32'(a_occ), 1);
        tick(1'b0);
        chk("skid_occ0", 32'(a_occ), 0);
        chk("skid_sb_empty", 32'(sb.size()), 0);

        // Flush deferred across a stall
        do_reset();
        in_valid = 1'b1; in_data = 8'h05; out_ready = 1'b0;
        tick(1'b0);
        in_valid = 1'b0; stall = 1'b1;
        tick(1'b0);
        flush = 1'b1;
        tick(1'b0);
        flush = 1'b0;
        #1;
        chk("stall_out_valid", 32'(a_out_valid), 0);
        chk("stall_pend", 32'(a_flush_pend), 1);
        chk("stall_data", 32'(a_out_data), 32'h05);
        chk("stall_occ", 32'(a_occ), 1);
        chk("stall_in_ready", 32'(a_in_ready), 0);
        tick(1'b0);
        stall = 1'b0; out_ready = 1'b1;
        #1;
        chk("f_out_valid", 32'(a_out_valid), 0);
        chk("f_in_ready", 32'(a_in_ready), 0);
        tick(1'b0);
        sb.delete();
        chk("f_occ", 32'(a_occ), 0);
        chk("f_clr_data", 32'(a_out_data), 0);
        chk("f_pend_clr", 32'(a_flush_pend), 0);
        chk("f_keep_data", 32'(b_out_data), 32'h05);

        // Immediate flush with two entries held
        do_reset();
        in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b0;
        tick(1'b0);
        in_data = 8'h22;
        tick(1'b0);
        chk("f2_occ_pre", 32'(a_occ), 2);
        in_valid = 1'b0; flush = 1'b1;
        #1;
        chk("f2_out_valid", 32'(a_out_valid), 0);
        chk("f2_in_ready", 32'(a_in_ready), 0);
        tick(1'b0);
        flush = 1'b0;
        sb.delete();
        chk("f2_occ", 32'(a_occ), 0);
        chk("f2_b_occ", 32'(b_occ), 0);
        chk("f2_clr_data", 32'(a_out_data), 0);
        chk("f2_keep_data", 32'(b_out_data), 32'h11);
        chk("f2_b_valid", 32'(b_out_valid), 0);

        // Backpressure counter saturation
        do_reset();
        in_valid = 1'b1; in_data = 8'h33; out_ready = 1'b0;
        tick(1'b0);
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0);
            if (i == 13)
                chk("bp_14", 32'(a_bp), 14);
            if (i == 14)
                chk("bp_sat", 32'(a_bp), 15);
        end
        chk("bp_hold", 32'(a_bp), 15);
        chk("bp_wide", 32'(b_bp), 20);

        // Asynchronous reset with two entries held
        do_reset();
        in_valid = 1'b1; in_data = 8'h44; out_ready = 1'b0;
        tick(1'b0);
        in_data = 8'h55;
        tick(1'b0);
        chk("ar_occ_pre", 32'(a_occ), 2);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_out_valid", 32'(a_out_valid), 0);
        chk("ar_occ", 32'(a_occ), 0);
        chk("ar_bp", 32'(a_bp), 0);
        chk("ar_in_ready", 32'(a_in_ready), 0);
        chk("ar_data", 32'(a_out_data), 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
